serial_mag_cmp: RTL and testbench

//  Bit-serial magnitude comparator sequencer for the comparator datapath.
//  - Accepts an operand pair (a, b) plus enable g over a valid/ready handshake.
//  - Walks the operands MSB-first through a 1-bit compare cell, one bit per clock.
//  - Returns one-hot gt/lt/eq flags over a second valid/ready handshake.
//  - Extends the combinational 3-bit compare to WIDTH bits, trading latency for area.

---
 rtl/serial_mag_cmp_pkg.sv | 16 +
 rtl/serial_mag_cmp_if.sv | 28 ++
 rtl/serial_mag_cmp_bit_cell.sv | 23 ++
 rtl/serial_mag_cmp.sv | 107 ++++++++++
 tb/tb_serial_mag_cmp.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_mag_cmp_pkg.sv
// Shared types and result encodings for the bit-serial magnitude comparator.
// One-hot result codes are ordered {gt, lt, eq} so they map straight onto the flags.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [2:0] RES_GT   = 3'b100;
    localparam logic [2:0] RES_LT   = 3'b010;
    localparam logic [2:0] RES_EQ   = 3'b001;
    localparam logic [2:0] RES_NONE = 3'b000;

endpackage

// File: rtl/serial_mag_cmp_if.sv
// Operand/result bundle for serial_mag_cmp.
// Both channels use valid/ready: a transfer happens on a rising clock edge where
// valid and ready are both high; the producer holds valid and its payload until then.
interface serial_mag_cmp_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic             g;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic             gt;
    logic             lt;
    logic             eq;
    logic             busy;

    modport master (
        output in_valid, g, a, b, out_ready,
        input  in_ready, out_valid, gt, lt, eq, busy
    );

    modport slave (
        input  in_valid, g, a, b, out_ready,
        output in_ready, out_valid, gt, lt, eq, busy
    );
endinterface

// File: rtl/serial_mag_cmp_bit_cell.sv
// One-bit compare cell: classifies a single bit pair as gt/lt/eq, or none when disabled.
module cmp_bit_cell
    import cmp_pkg::*;
(
    input  logic       g,
    input  logic       a,
    input  logic       b,
    output logic [2:0] res
);

    // Combinational classification of the current bit pair.
    always_comb begin
        res = RES_EQ;
        if (!g) begin
            res = RES_NONE;
        end else if (a & ~b) begin
            res = RES_GT;
        end else if (~a & b) begin
            res = RES_LT;
        end
    end

endmodule

// File: rtl/serial_mag_cmp.sv
// Bit-serial magnitude comparator: walks operands MSB-first through cmp_bit_cell,
// one bit per clock, and returns one-hot gt/lt/eq flags.
// Optional macro SERIAL_MAG_CMP_EARLY_EXIT_EN: finish as soon as the first
// differing bit is seen instead of always spending WIDTH shift cycles.
module serial_mag_cmp
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              CLOCK_50,
    input  logic              RST,
    serial_mag_cmp_if.slave   bus
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t             state;
    logic [WIDTH-1:0]   sa;
    logic [WIDTH-1:0]   sb;
    logic               sg;
    logic [CNT_W-1:0]   cnt;
    logic               out_valid;
    logic [2:0]         flags;
    logic [2:0]         bit_res;
    logic               bit_diff;
    logic               decided;

    cmp_bit_cell u_cell (
        .g   (sg),
        .a   (sa[WIDTH-1]),
        .b   (sb[WIDTH-1]),
        .res (bit_res)
    );

    assign bit_diff = (bit_res == RES_GT) || (bit_res == RES_LT);
    // Once gt or lt is latched, later bits no longer matter.
    assign decided  = flags[2] | flags[1];

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = out_valid;
    assign bus.gt        = flags[2];
    assign bus.lt        = flags[1];
    assign bus.eq        = flags[0];

    // Sequencer: load operands, shift one bit per clock, then hold the result.
    // A g=0 load enters DONE with out_valid low and presents it one cycle later,
    // so the disabled case still returns its (all-zero) result one clock after accept.
    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            state     <= IDLE;
            sa        <= '0;
            sb        <= '0;
            sg        <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            flags     <= RES_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sa    <= bus.a;
                        sb    <= bus.b;
                        sg    <= bus.g;
                        cnt   <= CNT_W'(WIDTH - 1);
                        flags <= RES_NONE;
                        state <= bus.g ? SHIFT : DONE;
                    end
                end
                SHIFT: begin
                    sa  <= {sa[WIDTH-2:0], 1'b0};
                    sb  <= {sb[WIDTH-2:0], 1'b0};
                    cnt <= cnt - CNT_W'(1);
                    if (!decided && bit_diff) begin
                        flags <= bit_res;
                    end
                    if (cnt == '0) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        if (!decided && !bit_diff) begin
                            flags <= RES_EQ;
                        end
                    end
`ifdef SERIAL_MAG_CMP_EARLY_EXIT_EN
                    if (!decided && bit_diff) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
`endif
                end
                DONE: begin
                    if (out_valid && bus.out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_mag_cmp.sv
// Self-checking bench for serial_mag_cmp (WIDTH=8), honours SERIAL_MAG_CMP_EARLY_EXIT_EN.
module tb_serial_mag_cmp;

    localparam int W = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;

    logic [2:0] exp_q[$];
    int         lat_q[$];

    serial_mag_cmp_if #(.WIDTH(W)) bus ();

    serial_mag_cmp #(.WIDTH(W)) dut (
        .CLOCK_50 (clk),
        .RST      (rst),
        .bus      (bus)
    );

    // Clock and free-running edge counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: flags from plain integer compare.
    function automatic logic [2:0] exp_flags(input logic [W-1:0] av, input logic [W-1:0] bv,
                                             input logic gv);
        if (!gv)          return 3'b000;
        else if (av > bv) return 3'b100;
        else if (av < bv) return 3'b010;
        else              return 3'b001;
    endfunction

    // Reference model: edges from accept to out_valid.
    function automatic int exp_lat(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic gv);
        if (!gv) return 1;
`ifdef SERIAL_MAG_CMP_EARLY_EXIT_EN
        for (int i = W - 1; i >= 0; i--) begin
            if (av[i] != bv[i]) return W - i;
        end
`endif
        return W;
    endfunction

    function automatic logic [2:0] dut_flags();
        return {bus.gt, bus.lt, bus.eq};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
            dut_flags() !== 3'b000) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b flags=%b, want 1 0 0 000",
                     bus.in_ready, bus.out_valid, bus.busy, dut_flags());
        end
    endtask

    // Drive one op, measure latency, hold out_ready low for 'hold' cycles, then release.
    task automatic do_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic gv, input int hold);
        int         lat;
        int         waited;
        int         lat_exp;
        logic [2:0] fexp;
        @(negedge clk);
        bus.out_ready = (hold == 0);
        waited = 0;
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_accept: in_ready=%b after %0d cycles, want 1", name, bus.in_ready, waited);
            return;
        end
        bus.in_valid = 1'b1;
        bus.a = av;
        bus.b = bv;
        bus.g = gv;
        exp_q.push_back(exp_flags(av, bv, gv));
        lat_q.push_back(exp_lat(av, bv, gv));
        @(posedge clk);
        @(negedge clk);
        // Scramble operands after accept; the DUT must ignore them.
        bus.in_valid = 1'b0;
        bus.a = W'($urandom_range(0, 255));
        bus.b = W'($urandom_range(0, 255));
        bus.g = 1'($urandom_range(0, 1));
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        fexp    = exp_q.pop_front();
        lat_exp = lat_q.pop_front();
        checks++;
        if (lat !== lat_exp) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles, want %0d", name, lat, lat_exp);
        end
        checks++;
        if (dut_flags() !== fexp) begin
            errors++;
            $display("FAIL %s_flags: got gt/lt/eq=%b, want %b", name, dut_flags(), fexp);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            if (dut_flags() !== fexp || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL %s_hold%0d: flags=%b out_valid=%b in_ready=%b busy=%b, want %b 1 0 1",
                         name, i, dut_flags(), bus.out_valid, bus.in_ready, bus.busy, fexp);
            end
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0 ||
            dut_flags() !== fexp) begin
            errors++;
            $display("FAIL %s_release: out_valid=%b in_ready=%b busy=%b flags=%b, want 0 1 0 %b",
                     name, bus.out_valid, bus.in_ready, bus.busy, dut_flags(), fexp);
        end
    endtask

    task automatic test_equal();
        do_op("eq_a5", 8'hA5, 8'hA5, 1'b1, 0);
    endtask

    task automatic test_greater();
        do_op("gt_80_7f", 8'h80, 8'h7F, 1'b1, 0);
    endtask

    task automatic test_disabled();
        do_op("g0_3c_ff", 8'h3C, 8'hFF, 1'b0, 0);
    endtask

    task automatic test_backpressure();
        do_op("lt_hold", 8'h01, 8'h02, 1'b1, 5);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            do_op("rand", W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                  1'($urandom_range(0, 3) != 0), $urandom_range(0, 2));
        end
    endtask

    task automatic test_mid_reset();
        logic [W-1:0] bv;
`ifdef SERIAL_MAG_CMP_EARLY_EXIT_EN
        bv = 8'h01;
`else
        bv = 8'hFF;
`endif
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a = 8'h00;
        bus.b = bv;
        bus.g = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        // Third SHIFT cycle: after two SHIFT edges.
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL midrst_pre%0d: out_valid=%b busy=%b, want 0 1", i, bus.out_valid, bus.busy);
            end
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || dut_flags() !== 3'b000) begin
            errors++;
            $display("FAIL midrst_after: in_ready=%b out_valid=%b flags=%b, want 1 0 000",
                     bus.in_ready, bus.out_valid, dut_flags());
        end
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL midrst_quiet%0d: out_valid=%b in_ready=%b, want 0 1",
                         i, bus.out_valid, bus.in_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] va[8];
        logic [W-1:0] vb[8];
        logic         vg[8];
        int           acc[8];
        va[0] = 8'h00; vb[0] = 8'hFF; vg[0] = 1'b1;
        va[1] = 8'hFF; vb[1] = 8'h00; vg[1] = 1'b1;
        for (int i = 2; i < 8; i++) begin
            va[i] = W'($urandom_range(0, 255));
            vb[i] = (i == 5) ? va[i] : W'($urandom_range(0, 255));
            vg[i] = 1'($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        fork
            begin : driver
                for (int i = 0; i < 8; i++) begin
                    int waited;
                    waited = 0;
                    while (!bus.in_ready && waited < 50) begin
                        @(negedge clk);
                        waited++;
                    end
                    bus.in_valid = 1'b1;
                    bus.a = va[i];
                    bus.b = vb[i];
                    bus.g = vg[i];
                    acc[i] = cyc;
                    exp_q.push_back(exp_flags(va[i], vb[i], vg[i]));
                    @(posedge clk);
                    @(negedge clk);
                    bus.in_valid = 1'b0;
                end
            end
            begin : monitor
                int got;
                int t;
                logic [2:0] fexp;
                got = 0;
                t = 0;
                while (got < 8 && t < 400) begin
                    @(negedge clk);
                    t++;
                    if (bus.out_valid && bus.out_ready) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL b2b_dup: result %b with empty queue", dut_flags());
                        end else begin
                            fexp = exp_q.pop_front();
                            if (dut_flags() !== fexp) begin
                                errors++;
                                $display("FAIL b2b_flags%0d: got %b, want %b", got, dut_flags(), fexp);
                            end
                        end
                        got++;
                    end
                end
                checks++;
                if (got != 8) begin
                    errors++;
                    $display("FAIL b2b_count: got %0d results, want 8", got);
                end
            end
        join
        checks++;
        if (acc[1] - acc[0] != exp_lat(va[0], vb[0], vg[0]) + 2) begin
            errors++;
            $display("FAIL b2b_gap: accept spacing %0d, want %0d", acc[1] - acc[0],
                     exp_lat(va[0], vb[0], vg[0]) + 2);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: queue=%0d out_valid=%b, want 0 0", exp_q.size(), bus.out_valid);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.g         = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_equal();
        test_greater();
        test_disabled();
        test_backpressure();
        test_mid_reset();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
